// File: rtl/rx_deframer.sv
// Serial receive deframer: recovers start/data/parity/stop fields one bit per clock
// and hands each byte to a one-entry holding register with valid/ready and overrun flag.
module rx_deframer (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    input  logic [1:0] par,
    input  logic       dnum,
    input  logic       snum,
    input  logic       rx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_perr,
    output logic       rx_ferr,
    output logic       rx_ovr,
    output logic       busy
);

    typedef enum logic [2:0] {
        HUNT  = 3'd0,
        IDLE  = 3'd1,
        DATA  = 3'd2,
        PAR   = 3'd3,
        STOP1 = 3'd4,
        STOP2 = 3'd5
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic [2:0] r_cnt;
    logic [7:0] r_shift;
    logic [1:0] r_par;
    logic       r_dnum;
    logic       r_snum;
    logic       r_perr;
    logic       r_ferr;

    logic [7:0] w_data;
    logic       w_parity;
    logic       w_frameFerr;
    logic       w_complete;
    logic       w_load;
    logic       w_consume;

    assign w_data      = {r_shift[7] & ~r_dnum, r_shift[6:0]};
    assign w_parity    = ^w_data;
    assign w_frameFerr = r_ferr | ~rxd;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= HUNT;
        end else begin
            r_state <= w_next;
        end
    end

    // A frame with a framing error falls back to HUNT so a held-low line is not a new start.
    always_comb begin
        w_next = r_state;
        case (r_state)
            HUNT:    if (rxd) w_next = IDLE;
            IDLE:    if (!rxd) w_next = DATA;
            DATA:    if (r_cnt == 3'd7) w_next = PAR;
            PAR:     w_next = STOP1;
            STOP1: begin
                if (!r_snum) begin
                    w_next = STOP2;
                end else begin
                    w_next = w_frameFerr ? HUNT : IDLE;
                end
            end
            STOP2:   w_next = w_frameFerr ? HUNT : IDLE;
            default: w_next = HUNT;
        endcase
    end

    always_comb begin
        busy       = (r_state != HUNT) && (r_state != IDLE);
        w_complete = ((r_state == STOP1) && r_snum) || (r_state == STOP2);
        w_load     = w_complete && (!rx_valid || rx_ready);
        w_consume  = rx_valid && rx_ready && !w_complete;
    end

    // Per-frame options are captured on the start edge and held for the whole frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt   <= 3'd0;
            r_shift <= 8'd0;
            r_par   <= 2'd0;
            r_dnum  <= 1'b0;
            r_snum  <= 1'b0;
            r_perr  <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!rxd) begin
                        r_par  <= par;
                        r_dnum <= dnum;
                        r_snum <= snum;
                        r_cnt  <= 3'd0;
                        r_perr <= 1'b0;
                        r_ferr <= 1'b0;
                    end
                end
                DATA: begin
                    r_shift <= {rxd, r_shift[7:1]};
                    r_cnt   <= r_cnt + 3'd1;
                end
                PAR: begin
                    case (r_par)
                        2'b00:   r_perr <= rxd ^ w_parity;
                        2'b11:   r_perr <= ~(rxd ^ w_parity);
                        default: r_perr <= 1'b0;
                    endcase
                end
                STOP1, STOP2: r_ferr <= w_frameFerr;
                default: ;
            endcase
        end
    end

    // Completion wins over a plain consume; a completion into a full, unaccepted register is dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_data  <= 8'd0;
            rx_valid <= 1'b0;
            rx_perr  <= 1'b0;
            rx_ferr  <= 1'b0;
            rx_ovr   <= 1'b0;
        end else if (w_load) begin
            rx_data  <= w_data;
            rx_perr  <= r_perr;
            rx_ferr  <= w_frameFerr;
            rx_valid <= 1'b1;
        end else if (w_complete) begin
            rx_ovr   <= 1'b1;
        end else if (w_consume) begin
            rx_valid <= 1'b0;
            rx_perr  <= 1'b0;
            rx_ferr  <= 1'b0;
            rx_ovr   <= 1'b0;
        end
    end

endmodule

// File: doc/rx_deframer.md
# rx_deframer

Serial receive deframer that sits directly downstream of the team's one-bit-per-clock serial transmitter. It samples the line once per clock, recovers start / data / parity / stop fields using the transmitter's frame format and configuration encoding, checks parity and framing, and presents each byte in a one-entry holding register with a valid/ready handshake and an overrun flag.

## Interface
- No parameters. Frame format is fixed; per-frame options come from ports.
- clk  input  1  system clock. Rising-edge active; one line bit per cycle.
- rst  input  1  reset. Asynchronous, active-low.
- rxd  input  1  serial line. Idles high; same clock domain as the transmitter, so no synchronizer.
- par  input  2  parity mode:
  - 00: parity bit = XOR of the data bits.
  - 11: parity bit = XNOR of the data bits.
  - 01/10: parity slot is present but its value is ignored.
- dnum  input  1  1 = 7 data bits. Data slot 7 is present but ignored, and rx_data[7] is forced to 0.
- snum  input  1  0 = two stop bits, 1 = one stop bit.
- rx_ready  input  1  consumer accepts the held byte on an edge where rx_valid=1.
- rx_data  output  8  held data byte, LSB received first.
- rx_valid  output  1  holding register full.
- rx_perr  output  1  parity error of the held byte.
- rx_ferr  output  1  framing error (a stop slot sampled 0) of the held byte.
- rx_ovr  output  1  a completed frame was dropped because the holding register was full.
- busy  output  1  frame in progress (any state other than HUNT or IDLE).

## Operation
- Frame, one bit per cycle:
  - start bit (0),
  - 8 data slots, LSB first,
  - 1 parity slot (always present),
  - 1 or 2 stop slots (1).
- States: HUNT, IDLE, DATA (3-bit counter 0..7), PAR, STOP1, STOP2.
- HUNT: wait for rxd=1, then go to IDLE. This is the reset state.
- IDLE: rxd=0 at an edge means a start bit is detected.
  - par, dnum and snum are latched on that edge and held for the whole frame; later changes do not affect the frame in progress.
  - Go to DATA with count 0.
- DATA: shift rxd into a shift register, 8 edges; go to PAR after count 7. When dnum=1, bit 7 is masked to 0.
- PAR: compute the expected parity over the masked data bits and compare it with rxd to produce the parity-error bit. Modes 01/10 never produce a parity error. Go to STOP1.
- STOP1: rxd=0 sets the frame's ferr bit.
  - Two stop bits configured: go to STOP2.
  - One stop bit: the frame completes.
- STOP2: rxd=0 sets ferr; the frame completes.
- Frame completion:
  - Next state is IDLE if the frame had no ferr, otherwise HUNT, so a held-low line is not taken as a new start.
  - Delivery: if rx_valid=0, or rx_valid=1 and rx_ready=1 on the same edge, load rx_data, rx_perr and rx_ferr, and rx_valid becomes (or stays) 1.
  - Otherwise the frame is dropped, rx_ovr is set, and the held contents are unchanged.
- Consume: on an edge with rx_valid=1, rx_ready=1 and no completing frame, rx_valid, rx_perr and rx_ferr clear.
- rx_ovr is sticky; it clears only on a consume edge or by reset.
- Frames with a parity or framing error are still delivered, with the flags set.

## Timing
- Reset (rst=0, asynchronous): state HUNT; rx_data=0; rx_valid, rx_perr, rx_ferr, rx_ovr and busy all 0. Reset mid-frame aborts the frame with nothing delivered.
- Let edge S be the edge where IDLE samples rxd=0. Sampling then proceeds:
  - data bit i at edge S+1+i,
  - parity at S+9,
  - stop1 at S+10,
  - stop2 at S+11.
- rx_valid is high after edge S+10 (one stop bit) or S+11 (two stop bits).
- busy is high after S through the completion edge, then low.
- Back-to-back frames: after a clean completion, the state is IDLE, so a start bit on the very next edge is accepted with zero gap.
- After a frame with a framing error: at least one rxd=1 sample is needed before the next start bit is accepted.
- rx_ready has no effect while rx_valid=0.
- The handshake is purely registered; there is no combinational path from rx_ready to any output.

## Test plan
- Byte 0xA5, par=00, dnum=0, snum=1, clean frame -> rx_valid rises after edge S+10; rx_data=0xA5, rx_perr=0, rx_ferr=0.
- Byte 0x55 sent with a wrong parity bit, par=11 -> rx_perr=1, rx_data=0x55. Repeated with par=01 -> rx_perr=0.
- dnum=1, data slots 0x7F then slot7=1, snum=0 -> rx_data=0x7F with bit 7 forced 0; rx_valid rises after S+11; parity is checked over 7 bits.
- Stop slot driven 0, then rxd held 0 for 5 cycles -> rx_ferr=1 delivered; no new frame starts until rxd returns to 1.
- Two back-to-back frames 0x01, 0x02 with rx_ready=0 -> first held; rx_ovr=1 and rx_data stays 0x01. Pulse rx_ready -> rx_valid=0, rx_ovr=0. A completion on the same edge as a consume -> new byte loads, rx_valid stays 1, no overrun.
- Assert rst=0 at edge S+4 mid-frame, release with rxd=0 -> outputs at reset values and no start accepted until rxd=1 has been sampled.
